// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side adapter between a single-clock FIFO (ren/empty interface with a
// registered dataout, 1-cycle read latency) and a valid/ready stream consumer.
// A 2-entry skid buffer absorbs the word that is still in flight when the
// consumer stalls, so 1 word/clk is sustained and no popped word is lost.
//
// Ports:
//   clk           single clock, all state on the rising edge
//   rst           synchronous, active-high reset
//   fifo_empty    FIFO empty flag
//   fifo_dataout  FIFO read data, valid the cycle after fifo_ren was high
//   fifo_ren      FIFO pop request (combinational, forced low in reset)
//   m_data        stream data (head of the skid buffer)
//   m_valid       stream data valid
//   m_ready       consumer ready; a word transfers when m_valid & m_ready
//   rd_count      words accepted downstream, modulo 2^CNT_W
//   idle          nothing buffered or in flight and the FIFO is empty
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dataout,
    output logic             fifo_ren,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic             idle
);

    // In-order skid queue; entry 0 is the head presented on m_data.
    logic [WIDTH-1:0] skid_reg  [0:1];
    logic [WIDTH-1:0] skid_next [0:1];

    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             pend_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] count_reg;

    logic             pop;
    logic             tail_sel;

    assign pop = valid_reg & m_ready;

    // Words that will be held after this edge, counting the one arriving now.
    // pop implies occ >= 1, so this never underflows; it never exceeds 2
    // because a new read is only issued when it is at most 1.
    assign occ_next = occ_reg + {1'b0, pend_reg} - {1'b0, pop};

    // Issuing a read is safe only if its word will have a free slot when it
    // lands next cycle. The m_ready -> fifo_ren path is intentionally
    // combinational so a pop frees a slot for a read in the same cycle.
    assign fifo_ren = !rst && !fifo_empty && (occ_next <= 2'd1);

    // The arriving word goes to position occ - pop. With pend set, occ is 0 or
    // 1, so that position is 1 only when one word is held and it is not leaving.
    assign tail_sel = (occ_reg == 2'd1) && !pop;

    always_comb begin
        skid_next[0] = pop ? skid_reg[1] : skid_reg[0];
        skid_next[1] = skid_reg[1];
        if (pend_reg) begin
            if (tail_sel) begin
                skid_next[1] = fifo_dataout;
            end else begin
                skid_next[0] = fifo_dataout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // A word in flight is dropped here: the FIFO has already advanced
            // its read pointer, so it cannot be recovered.
            skid_reg[0] <= '0;
            skid_reg[1] <= '0;
            occ_reg     <= 2'd0;
            pend_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            count_reg   <= '0;
        end else begin
            skid_reg[0] <= skid_next[0];
            skid_reg[1] <= skid_next[1];
            occ_reg     <= occ_next;
            pend_reg    <= fifo_ren;
            valid_reg   <= (occ_next != 2'd0);
            if (pop) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign m_data   = skid_reg[0];
    assign m_valid  = valid_reg;
    assign rd_count = count_reg;
    assign idle     = fifo_empty && !pend_reg && (occ_reg == 2'd0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Self-checking bench for fifo_rd_stream. A behavioural 16-slot FIFO (holds 15
// words) feeds the DUT. Every word accepted by the FIFO is pushed to a
// scoreboard queue; words delivered downstream are recorded by a monitor and
// compared in order by the scenario tasks. A narrow counter width is used so
// rd_count wraps during the run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_rd_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dataout = '0;
    logic             fifo_ren;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] rd_count;
    logic             idle;

    always #5 clk = ~clk;

    fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_ren     (fifo_ren),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .rd_count     (rd_count),
        .idle         (idle)
    );

    // ---------------- behavioural FIFO (no reset, 15 usable slots) ----------
    logic [WIDTH-1:0] fmem [0:15];
    logic [3:0]       wp = 4'd0;
    logic [3:0]       rp = 4'd0;
    int               fcount = 0;
    int               fifo_pops = 0;
    logic             wen;
    logic [WIDTH-1:0] wdata;
    logic             do_w;
    logic             do_r;

    assign fifo_empty = (fcount == 0);
    assign do_w = wen && (fcount < 15);
    assign do_r = fifo_ren && (fcount != 0);

    always @(posedge clk) begin
        if (do_w) begin
            fmem[wp] <= wdata;
            wp <= wp + 4'd1;
        end
        if (do_r) begin
            fifo_dataout <= fmem[rp];
            rp <= rp + 4'd1;
            fifo_pops <= fifo_pops + 1;
        end
        fcount <= fcount + int'(do_w) - int'(do_r);
    end

    // ---------------- monitor: records transfers, sampled at negedge --------
    logic [WIDTH-1:0] obs_mem [0:1023];
    int               mon_accepts = 0;
    int               ren_viol = 0;

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            obs_mem[mon_accepts % 1024] = m_data;
            mon_accepts++;
        end
        if (fifo_ren && fifo_empty) begin
            ren_viol++;
        end
    end

    // ---------------- scoreboard state ---------------------------------------
    logic [WIDTH-1:0] exp_q [$];
    int               obs_rd = 0;
    int               lost_total = 0;
    int               acc = 0;
    logic [CNT_W-1:0] exp_rd = '0;
    int               checks = 0;
    int               passes = 0;
    int               xfer_no = 0;

    // Inputs change 1 time unit after the rising edge; take effect at the next.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word to the FIFO; it is expected downstream only if accepted.
    task automatic push_write(input logic [WIDTH-1:0] d);
        wen = 1'b1;
        wdata = d;
        if (fcount < 15) begin
            exp_q.push_back(d);
            acc++;
        end
        tick();
        wen = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        wen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (idle && !m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        bit ok;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;
        tick();
        @(negedge clk);
        checks++; if (fifo_ren !== 1'b0) $display("FAIL rst_ren: got %b, required 0", fifo_ren); else passes++;
        checks++; if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", m_valid); else passes++;
        checks++; if (m_data !== 8'h00) $display("FAIL rst_data: got %h, required 00", m_data); else passes++;
        checks++; if (rd_count !== '0) $display("FAIL rst_count: got %0d, required 0", rd_count); else passes++;
        checks++; if (idle !== 1'b1) $display("FAIL rst_idle_empty: got %b, required 1", idle); else passes++;
        tick();
        push_write(8'h3C);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (fifo_ren !== 1'b0) $display("FAIL rst_ren_nonempty: got %b, required 0", fifo_ren); else passes++;
            checks++; if (m_valid !== 1'b0) $display("FAIL rst_valid_nonempty: got %b, required 0", m_valid); else passes++;
            checks++; if (idle !== 1'b0) $display("FAIL rst_idle_nonempty: got %b, required 0", idle); else passes++;
            tick();
        end
        rst = 1'b0;
        m_ready = 1'b1;
        wait_drain(ok);
        checks++; if (!ok) $display("FAIL reset_drain: got timeout, required drained"); else passes++;
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL sb_missing: got %0d undelivered, required 0", exp_q.size()); else passes++;
        exp_rd = exp_rd + CNT_W'(1);
        checks++; if (rd_count !== exp_rd) $display("FAIL reset_rd_count: got %0d, required %0d", rd_count, exp_rd); else passes++;
    endtask

    task automatic test_single();
        bit ok;
        int lat;
        int extra_ren;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;
        @(negedge clk);
        checks++; if (idle !== 1'b1) $display("FAIL single_idle_pre: got %b, required 1", idle); else passes++;
        tick();
        push_write(8'hA5);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_ren) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (!ok) $display("FAIL single_ren: got no fifo_ren, required one"); else passes++;
        lat = 0;
        extra_ren = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (fifo_ren) extra_ren++;
            if (m_valid) break;
        end
        checks++; if (lat != 2) $display("FAIL single_latency: got %0d cycles, required 2", lat); else passes++;
        checks++; if (extra_ren != 0) $display("FAIL single_ren_once: got %0d extra reads, required 0", extra_ren); else passes++;
        checks++; if (m_data !== 8'hA5) $display("FAIL single_data: got %h, required a5", m_data); else passes++;
        @(posedge clk);
        @(negedge clk);
        exp_rd = exp_rd + CNT_W'(1);
        checks++; if (m_valid !== 1'b0) $display("FAIL single_valid_len: got %b, required 0", m_valid); else passes++;
        checks++; if (rd_count !== exp_rd) $display("FAIL single_rd_count: got %0d, required %0d", rd_count, exp_rd); else passes++;
        checks++; if (idle !== 1'b1) $display("FAIL single_idle_post: got %b, required 1", idle); else passes++;
        tick();
        wait_drain(ok);
        checks++; if (!ok) $display("FAIL single_drain: got timeout, required drained"); else passes++;
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL sb_missing: got %0d undelivered, required 0", exp_q.size()); else passes++;
    endtask

    // Fill while stalled (the FIFO saturates and rejects the last write), then
    // release and require one transfer per cycle with back-to-back reads.
    task automatic test_streaming();
        bit ok;
        int run;
        int rens;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;
        m_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 18; i++) push_write(8'(i));
        checks++; if (acc != 17) $display("FAIL stream_accepted: got %0d writes, required 17", acc); else passes++;
        @(negedge clk);
        checks++; if (fifo_ren !== 1'b0) $display("FAIL stream_ren_stalled: got %b, required 0", fifo_ren); else passes++;
        tick();
        m_ready = 1'b1;
        run = 0;
        rens = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!m_valid) break;
            run++;
            if (fifo_ren) rens++;
            tick();
        end
        checks++; if (run != 17) $display("FAIL stream_run: got %0d consecutive, required 17", run); else passes++;
        checks++; if (rens != 15) $display("FAIL stream_reads: got %0d reads, required 15", rens); else passes++;
        tick();
        wait_drain(ok);
        checks++; if (!ok) $display("FAIL stream_drain: got timeout, required drained"); else passes++;
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL sb_missing: got %0d undelivered, required 0", exp_q.size()); else passes++;
        exp_rd = exp_rd + CNT_W'(17);
        checks++; if (rd_count !== exp_rd) $display("FAIL stream_rd_count: got %0d, required %0d", rd_count, exp_rd); else passes++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int run;
        int pops0;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;
        m_ready = 1'b0;
        pops0 = fifo_pops;
        for (int i = 0; i < 5; i++) push_write(8'h10 + 8'(i));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (fifo_ren !== 1'b0) $display("FAIL bp_ren: got %b, required 0", fifo_ren); else passes++;
            checks++; if (m_valid !== 1'b1) $display("FAIL bp_valid: got %b, required 1", m_valid); else passes++;
            checks++; if (m_data !== 8'h10) $display("FAIL bp_hold: got %h, required 10", m_data); else passes++;
            tick();
        end
        checks++; if (fifo_pops - pops0 != 2) $display("FAIL bp_reads: got %0d reads, required 2", fifo_pops - pops0); else passes++;
        m_ready = 1'b1;
        run = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!m_valid) break;
            run++;
            tick();
        end
        checks++; if (run != 5) $display("FAIL bp_run: got %0d consecutive, required 5", run); else passes++;
        tick();
        wait_drain(ok);
        checks++; if (!ok) $display("FAIL bp_drain: got timeout, required drained"); else passes++;
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL sb_missing: got %0d undelivered, required 0", exp_q.size()); else passes++;
        exp_rd = exp_rd + CNT_W'(5);
        checks++; if (rd_count !== exp_rd) $display("FAIL bp_rd_count: got %0d, required %0d", rd_count, exp_rd); else passes++;
    endtask

    task automatic test_random();
        bit ok;
        int viol0;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;
        viol0 = ren_viol;
        acc = 0;
        for (int i = 0; i < 5000 && acc < 200; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) push_write(8'($urandom));
            else tick();
        end
        checks++; if (acc != 200) $display("FAIL rand_writes: got %0d accepted, required 200", acc); else passes++;
        m_ready = 1'b1;
        wait_drain(ok);
        checks++; if (!ok) $display("FAIL rand_drain: got timeout, required drained"); else passes++;
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL sb_missing: got %0d undelivered, required 0", exp_q.size()); else passes++;
        exp_rd = exp_rd + CNT_W'(200);
        checks++; if (rd_count !== exp_rd) $display("FAIL rand_rd_count: got %0d, required %0d", rd_count, exp_rd); else passes++;
        checks++; if (ren_viol != viol0) $display("FAIL rand_ren_empty: got %0d reads while empty, required 0", ren_viol - viol0); else passes++;
    endtask

    // Reset while a read is in flight: every word already popped from the FIFO
    // but not yet transferred is gone; delivery resumes with the next entry.
    task automatic test_reset_mid();
        bit ok;
        int lost;
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_write(8'h60 + 8'(i));
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_ren) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (!ok) $display("FAIL mid_ren: got no fifo_ren, required one"); else passes++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (fifo_ren !== 1'b0) $display("FAIL mid_ren_forced: got %b, required 0", fifo_ren); else passes++;
        tick();
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        lost = fifo_pops - mon_accepts - lost_total;
        checks++; if (lost < 1) $display("FAIL mid_lost: got %0d dropped, required at least 1", lost); else passes++;
        for (int i = 0; i < lost && exp_q.size() != 0; i++) begin
            want = exp_q.pop_front();
            $display("dropped by reset data=%h", want);
        end
        lost_total += lost;
        exp_rd = CNT_W'(exp_q.size());
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_count !== '0) $display("FAIL mid_rd_count_zero: got %0d, required 0", rd_count); else passes++;
        checks++; if (m_valid !== 1'b0) $display("FAIL mid_valid: got %b, required 0", m_valid); else passes++;
        tick();
        wait_drain(ok);
        checks++; if (!ok) $display("FAIL mid_drain: got timeout, required drained"); else passes++;
        while (obs_rd < mon_accepts) begin
            got = obs_mem[obs_rd % 1024]; obs_rd++; checks++; xfer_no++;
            if (exp_q.size() == 0) $display("FAIL sb_extra: got %h, required no word", got);
            else begin
                want = exp_q.pop_front();
                $display("xfer %0d data=%h exp=%h", xfer_no, got, want);
                if (got !== want) $display("FAIL sb_order: got %h, required %h", got, want); else passes++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL sb_missing: got %0d undelivered, required 0", exp_q.size()); else passes++;
        checks++; if (rd_count !== exp_rd) $display("FAIL mid_rd_count: got %0d, required %0d", rd_count, exp_rd); else passes++;
    endtask

    initial begin
        rst = 1'b1;
        m_ready = 1'b0;
        wen = 1'b0;
        wdata = '0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
